mem_rr_arb: RTL
===============

Name: mem_rr_arb

Overview:
- N-port round-robin burst arbiter that shares one main-memory port (the `memory` model, burst interface) between several cache/DMA masters.
- Generalises the two-port cache arbitration to NPORTS requesters with fair rotation, burst locking and per-port read-data steering.
- Sits between the icache/dcache (plus optional extra masters) and memory.

Parameters:
- NPORTS, 3, number of requesting masters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, beat data width.
- BURSTLEN_WIDTH, 2, burst length field width; beats = burst_len+1.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- c_addr  in  NPORTS*ADDR_WIDTH  per-port address, port i at slice i.
- c_burst_len  in  NPORTS*BURSTLEN_WIDTH  per-port beats-1.
- c_rd  in  NPORTS  per-port read request.
- c_wr  in  NPORTS  per-port write request/beat strobe.
- c_data_in  in  NPORTS*DATA_WIDTH  per-port write data.
- c_data_out  out  DATA_WIDTH  read data, broadcast to all ports.
- c_waitrequest  out  NPORTS  per-port stall.
- c_rd_valid  out  NPORTS  per-port read beat valid.
- mm_addr  out  ADDR_WIDTH  memory address.
- mm_burst_len  out  BURSTLEN_WIDTH  memory burst length.
- mm_rd  out  1  memory read command.
- mm_wr  out  1  memory write beat.
- mm_data_out  out  DATA_WIDTH  memory write data.
- mm_data_in  in  DATA_WIDTH  memory read data.
- mm_waitrequest  in  1  memory stall.
- mm_rd_valid  in  1  memory read beat valid.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, rr_ptr=0, beat_cnt=0.
  - mm_rd=0, mm_wr=0.
  - c_waitrequest all 1, c_rd_valid all 0.
- Handshake (all interfaces):
  - A command or beat is accepted on a rising edge where (rd|wr) is high and waitrequest is low.
  - Masters hold addr, burst_len and rd/wr stable until accepted.
- State machine:
  - IDLE:
    - All c_waitrequest=1; mm_rd=mm_wr=0.
    - If any c_rd|c_wr is high, pick the first requester at or after rr_ptr (modular search).
    - Register it as grant, capture beats=burst_len+1, beat_cnt=0.
    - Go to RD_CMD if its c_rd=1, else WR.
    - This is one cycle of arbitration latency. If rd and wr are both high, read wins.
  - RD_CMD:
    - mm_addr/mm_burst_len/mm_rd come from the grant port; mm_wr=0.
    - c_waitrequest[grant]=mm_waitrequest; other ports=1.
    - On accept go to RD_DATA.
  - RD_DATA:
    - mm_rd=0; c_waitrequest all 1.
    - c_rd_valid[grant]=mm_rd_valid; c_data_out=mm_data_in.
    - Each mm_rd_valid increments beat_cnt.
    - On the last beat go to IDLE and set rr_ptr=(grant+1) mod NPORTS.
  - WR:
    - mm_addr/mm_burst_len/mm_wr/mm_data_out come from the grant port.
    - c_waitrequest[grant]=mm_waitrequest.
    - Each accepted beat increments beat_cnt.
    - On the last beat go to IDLE and update rr_ptr as above.
    - If c_wr drops mid-burst, mm_wr=0 and the burst stays locked to grant.
- Outside RD_DATA all c_rd_valid=0. mm_rd_valid in a state other than RD_DATA is ignored and flagged by a sim-only assertion.
- Fairness: a port requesting continuously is granted within NPORTS-1 other bursts.
- Back-to-back: a new burst starts at the earliest 1 cycle after the previous burst ends (IDLE cycle).
- Counters: beat_cnt is BURSTLEN_WIDTH+1 bits. Max burst 2^BURSTLEN_WIDTH beats with no wrap.
- Reset mid-burst: immediate return to the reset state. Any partial memory transaction is abandoned, and the memory is reset by the same reset_n.

Test Plan:
- Single port 0 read, burst_len=3, memory has 0 wait states:
  - mm_rd is seen 1 cycle after c_rd.
  - 4 c_rd_valid[0] pulses with mm_data_in values 0x10..0x13.
  - Back in IDLE; rr_ptr=1.
- Ports 0, 1 and 2 all request reads simultaneously and continuously with burst_len=0:
  - Grant order is 0,1,2,0,1,2.
  - Each c_rd_valid[i] goes only to the granted port; the others stay 0.
- Port 1 write burst_len=3 with mm_waitrequest high on beats 2 and 3 for 2 cycles:
  - Exactly 4 accepted mm_wr beats with data 0xA0..0xA3.
  - c_waitrequest[1] mirrors mm_waitrequest; ports 0 and 2 see waitrequest=1 throughout.
- Port 2 asserts c_rd and c_wr together:
  - A read burst is issued.
  - After it completes, the held c_wr wins the next arbitration if there is no other requester.
- Port 0 in RD_DATA after 2 of 4 beats, then reset_n pulsed low:
  - mm_rd=0 and c_waitrequest=all 1 immediately (asynchronous).
  - After release the state is IDLE and rr_ptr=0.

Source files
------------

// File: rtl/mem_rr_arb.sv
// Purpose: N-port round-robin burst arbiter sharing one burst memory port between cache/DMA masters.
// Latency: one IDLE arbitration cycle per burst; command, write beats and read beats then pass through combinationally.
// Backpressure: mm_waitrequest is mirrored to the granted port only; every other port is held stalled.
// Ports: clock/reset_n; c_* are the flattened per-port master interfaces (port i at slice i);
//        mm_* is the single burst memory interface; c_data_out is broadcast and c_rd_valid steers it.
module mem_rr_arb #(
  parameter int NPORTS         = 3,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int BURSTLEN_WIDTH = 2
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NPORTS*ADDR_WIDTH-1:0]     c_addr,
  input  logic [NPORTS*BURSTLEN_WIDTH-1:0] c_burst_len,
  input  logic [NPORTS-1:0]                c_rd,
  input  logic [NPORTS-1:0]                c_wr,
  input  logic [NPORTS*DATA_WIDTH-1:0]     c_data_in,
  output logic [DATA_WIDTH-1:0]            c_data_out,
  output logic [NPORTS-1:0]                c_waitrequest,
  output logic [NPORTS-1:0]                c_rd_valid,
  output logic [ADDR_WIDTH-1:0]            mm_addr,
  output logic [BURSTLEN_WIDTH-1:0]        mm_burst_len,
  output logic                             mm_rd,
  output logic                             mm_wr,
  output logic [DATA_WIDTH-1:0]            mm_data_out,
  input  logic [DATA_WIDTH-1:0]            mm_data_in,
  input  logic                             mm_waitrequest,
  input  logic                             mm_rd_valid
);

  localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int CW = BURSTLEN_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] grant, grant_nxt;
  logic [IW-1:0] rr_ptr, rr_ptr_nxt;
  logic [CW-1:0] beats, beats_nxt;
  logic [CW-1:0] beat_cnt, beat_cnt_nxt;

  // Unflattened views of the per-port buses.
  logic [ADDR_WIDTH-1:0]     addr_a [NPORTS];
  logic [BURSTLEN_WIDTH-1:0] len_a  [NPORTS];
  logic [DATA_WIDTH-1:0]     wdat_a [NPORTS];

  for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
    assign addr_a[i] = c_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_a[i]  = c_burst_len[i*BURSTLEN_WIDTH +: BURSTLEN_WIDTH];
    assign wdat_a[i] = c_data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first requester at or after rr_ptr, wrapping modulo NPORTS.
  logic [NPORTS-1:0] req;
  logic [IW-1:0]     pick;
  logic              pick_vld;

  assign req = c_rd | c_wr;

  always_comb begin
    int idx;
    pick     = rr_ptr;
    pick_vld = 1'b0;
    idx      = 0;
    for (int k = 0; k < NPORTS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (!pick_vld && req[idx]) begin
        pick     = IW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  logic          last_beat;
  logic [IW-1:0] ptr_after_grant;

  assign last_beat       = (beat_cnt + CW'(1)) == beats;
  assign ptr_after_grant = (grant == IW'(NPORTS - 1)) ? '0 : grant + IW'(1);

  // The data path always follows the grant; only the strobes are gated by state.
  assign mm_addr      = addr_a[grant];
  assign mm_burst_len = len_a[grant];
  assign mm_data_out  = wdat_a[grant];
  assign c_data_out   = mm_data_in;

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    beats_nxt     = beats;
    beat_cnt_nxt  = beat_cnt;
    mm_rd         = 1'b0;
    mm_wr         = 1'b0;
    c_waitrequest = '1;
    c_rd_valid    = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt    = pick;
          beats_nxt    = {1'b0, len_a[pick]} + CW'(1);
          beat_cnt_nxt = '0;
          // Read wins when a port raises rd and wr together; the held wr re-arbitrates later.
          state_nxt    = c_rd[pick] ? RD_CMD : WR;
        end
      end
      RD_CMD: begin
        mm_rd                = c_rd[grant];
        c_waitrequest[grant] = mm_waitrequest;
        if (c_rd[grant] && !mm_waitrequest) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        c_rd_valid[grant] = mm_rd_valid;
        if (mm_rd_valid) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
          if (last_beat) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ptr_after_grant;
          end
        end
      end
      WR: begin
        // A master pausing c_wr mid-burst keeps the lock; mm_wr simply drops.
        mm_wr                = c_wr[grant];
        c_waitrequest[grant] = mm_waitrequest;
        if (c_wr[grant] && !mm_waitrequest) begin
          beat_cnt_nxt = beat_cnt + CW'(1);
          if (last_beat) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ptr_after_grant;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beats    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beats    <= beats_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

`ifndef SYNTHESIS
  // A read beat with no burst in its data phase has no owner and is dropped.
  stray_rd_valid: assert property (@(posedge clock) disable iff (!reset_n)
                                   mm_rd_valid |-> (state == RD_DATA))
    else $error("mm_rd_valid outside RD_DATA");
`endif

endmodule
